mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
Multi-requester memory access unit between the core's requesters (instruction fetch, load/store, debug) and the single-port word-addressed memory. It arbitrates the requesters and turns byte-addressed, sized, sign/zero-extended loads and stores into word accesses. The memory has no byte enables, so sub-word stores are done as read-modify-write. It replaces direct control-to-memory wiring in the next-generation core top.

Parameters:
NUM_PORTS_P, 2, number of requesters (1..8)
DATA_W_P, 32, memory word width; 32 or 64 only
BYTE_ADDR_W_P, 12, byte address width; word address = byte_addr[BYTE_ADDR_W_P-1:OFF], where OFF = log2(DATA_W_P/8)
RR_MODE_P, 1, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset; asynchronous, active-low
req_valid_i  in  NUM_PORTS_P  request valid per port
req_ready_o  out  NUM_PORTS_P  request accepted this cycle
req_we_i  in  NUM_PORTS_P  1 = store
req_addr_i  in  NUM_PORTS_P x BYTE_ADDR_W_P  byte address
req_size_i  in  NUM_PORTS_P x 2  t_mem_size: 0 byte, 1 half, 2 word, 3 dword
req_unsigned_i  in  NUM_PORTS_P  zero-extend load
req_wdata_i  in  NUM_PORTS_P x DATA_W_P  store data, right-aligned
rsp_valid_o  out  NUM_PORTS_P  one-cycle response pulse
rsp_rdata_o  out  NUM_PORTS_P x DATA_W_P  extended load data; 0 for stores and errors
rsp_err_o  out  NUM_PORTS_P  misaligned or illegal size
mem_addr_o  out  BYTE_ADDR_W_P-OFF  word address
mem_rd_en_o  out  1  read strobe; data returns on mem_rdata_i the next cycle
mem_wr_en_o  out  1  write strobe
mem_wdata_o  out  DATA_W_P  write data
mem_rdata_i  in  DATA_W_P  read data

Behaviour:
- Reset: state IDLE, RR pointer 0, latched request cleared. All outputs are 0 while rstn_i is low. Reset mid-operation abandons the access: no response, and mem strobes drop immediately.
- Handshake: requester holds valid, addr, size and data stable until ready. req_ready_o is combinational, high only in IDLE and only for the arbitration winner. Acceptance cycle = T. No backpressure on responses.
- Arbitration, fixed mode: lowest valid index wins.
- Arbitration, RR mode: search starts at (last_grant+1) mod NUM_PORTS_P. Pointer updates at each grant.
- Error check at T:
  - Misaligned if addr is not a multiple of size bytes.
  - size=3 is illegal when DATA_W_P=32.
  - Error → RESP at T+1 with err=1, rdata=0, no memory strobe.
- FSM IDLE→(grant):
  - error → RESP
  - full-width store → WRITE
  - otherwise → READ
- READ: mem_rd_en_o=1 for one cycle → WAIT.
- WAIT: capture mem_rdata_i.
  - load: extract lane at addr[OFF-1:0], sign-extend unless unsigned; full-width is not extended → RESP
  - sub-word store: merge wdata into captured word at the lane → WRITE
- WRITE: mem_wr_en_o=1, mem_wdata_o = merged or full data → RESP.
- RESP: rsp_valid_o[grant]=1 for one cycle → IDLE.
- Latency (rsp_valid_o):
  - load T+3
  - full store T+2
  - sub-word store T+4
  - error T+1
- Next acceptance can occur in the IDLE cycle after RESP.
- mem_addr_o holds the latched word address from READ through WRITE and is 0 in IDLE.
- mem_wdata_o is 0 outside WRITE.
- Never more than one access outstanding; rd and wr strobes are never high together.

Decomposition:
- riscv_pkg additions:
  - t_mem_size enum
  - t_mau_state enum (IDLE, READ, WAIT, WRITE, RESP)
  - lane-extract/extend and lane-merge functions
- Sub-module rr_arbiter: NUM_PORTS_P/RR_MODE_P parameters, combinational grant, registered pointer.

Test Plan:
1. Reset: hold rstn_i low with req_valid_i=2'b11 → all ready, rsp and mem outputs 0. Release → port 0 granted first.
2. Memory word 4 = 0x8899AABB, DATA_W_P=32:
   - LB at 0x11 → mem_rd_en_o at T+1 with addr 4; rsp at T+3 with 0xFFFFFFAA
   - LBU at 0x11 → 0x000000AA
   - LH at 0x12 → 0xFFFF8899
3. SH at 0x12, wdata 0x00001234, same word → read at T+1, write at T+3 with mem_wdata_o=0x1234AABB, rsp at T+4 with rdata 0. SW at 0x10 → write at T+1, rsp at T+2, no read.
4. LW at 0x06 → rsp_err=1 at T+1, no strobes. size=3 at 0x08 with DATA_W_P=32 → err.
5. Both ports valid continuously:
   - RR_MODE_P=1 → grants alternate 0,1,0,1 over 4 loads
   - RR_MODE_P=0 → port 0 granted every time, port 1 starved
6. rstn_i dropped asynchronously during WAIT of a sub-word store → strobes 0 immediately, no rsp, memory unmodified. After release, a new LW completes normally.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared types and byte-lane helpers for the memory access unit.
// Lane helpers work on a 64-bit container so one set serves 32- and 64-bit memories.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } t_mem_size;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_RESP
    } t_mau_state;

    function automatic logic misaligned(input logic [2:0] off, input t_mem_size size);
        case (size)
            SZ_HALF:  return off[0];
            SZ_WORD:  return |off[1:0];
            SZ_DWORD: return |off;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] size_mask(input t_mem_size size);
        case (size)
            SZ_BYTE: return 64'h0000_0000_0000_00FF;
            SZ_HALF: return 64'h0000_0000_0000_FFFF;
            SZ_WORD: return 64'h0000_0000_FFFF_FFFF;
            default: return '1;
        endcase
    endfunction

    // Callers truncate to the memory width, so a word load on a 32-bit memory is unextended.
    function automatic logic [63:0] lane_extract(input logic [63:0] word, input logic [2:0] off,
                                                 input t_mem_size size, input logic uns);
        logic [63:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            SZ_BYTE: return {{56{sh[7] & ~uns}}, sh[7:0]};
            SZ_HALF: return {{48{sh[15] & ~uns}}, sh[15:0]};
            SZ_WORD: return {{32{sh[31] & ~uns}}, sh[31:0]};
            default: return sh;
        endcase
    endfunction

    function automatic logic [63:0] lane_merge(input logic [63:0] word, input logic [63:0] wdata,
                                               input logic [2:0] off, input t_mem_size size);
        logic [63:0] m;
        m = size_mask(size) << {off, 3'b000};
        return (word & ~m) | ((wdata << {off, 3'b000}) & m);
    endfunction

endpackage

// File: rtl/mem_access_unit_rr_arbiter.sv
// Requester arbiter: combinational grant, fixed priority or round-robin from a registered pointer.
// Pointer advances past the winner whenever the grant is taken.
module mem_access_unit_rr_arbiter #(
    parameter int NUM_PORTS_P = 2,
    parameter int RR_MODE_P   = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic [NUM_PORTS_P-1:0] i_req,
    input  logic                   i_take,
    output logic [NUM_PORTS_P-1:0] o_gnt,
    output logic [((NUM_PORTS_P > 1) ? $clog2(NUM_PORTS_P) : 1)-1:0] o_idx,
    output logic                   o_any
);
    localparam int IDX_W = (NUM_PORTS_P > 1) ? $clog2(NUM_PORTS_P) : 1;

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_start;
    logic [IDX_W-1:0] w_cand;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_next_ptr;
    logic             w_any;

    assign w_start = (RR_MODE_P != 0) ? r_ptr : '0;

    always_comb begin
        w_any  = 1'b0;
        w_idx  = '0;
        w_cand = '0;
        for (int k = 0; k < NUM_PORTS_P; k++) begin
            w_cand = IDX_W'((int'(w_start) + k) % NUM_PORTS_P);
            if (!w_any && i_req[w_cand]) begin
                w_any = 1'b1;
                w_idx = w_cand;
            end
        end
    end

    always_comb begin
        o_gnt = '0;
        for (int k = 0; k < NUM_PORTS_P; k++) begin
            o_gnt[k] = w_any && (w_idx == IDX_W'(k));
        end
    end

    assign o_idx      = w_idx;
    assign o_any      = w_any;
    assign w_next_ptr = (w_idx == IDX_W'(NUM_PORTS_P - 1)) ? '0 : w_idx + 1'b1;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_ptr <= '0;
        end else if (i_take && w_any) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Arbitrates requesters onto a single-port word memory; sub-word stores become read-modify-write.
// Latency: error 1, full store 2, load 3, sub-word store 4 cycles; one access outstanding, ready only in IDLE.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int NUM_PORTS_P   = 2,
    parameter int DATA_W_P      = 32,
    parameter int BYTE_ADDR_W_P = 12,
    parameter int RR_MODE_P     = 1
) (
    input  logic                                   clk_i,
    input  logic                                   rstn_i,
    input  logic [NUM_PORTS_P-1:0]                 req_valid_i,
    output logic [NUM_PORTS_P-1:0]                 req_ready_o,
    input  logic [NUM_PORTS_P-1:0]                 req_we_i,
    input  logic [NUM_PORTS_P-1:0][BYTE_ADDR_W_P-1:0] req_addr_i,
    input  logic [NUM_PORTS_P-1:0][1:0]            req_size_i,
    input  logic [NUM_PORTS_P-1:0]                 req_unsigned_i,
    input  logic [NUM_PORTS_P-1:0][DATA_W_P-1:0]   req_wdata_i,
    output logic [NUM_PORTS_P-1:0]                 rsp_valid_o,
    output logic [NUM_PORTS_P-1:0][DATA_W_P-1:0]   rsp_rdata_o,
    output logic [NUM_PORTS_P-1:0]                 rsp_err_o,
    output logic [BYTE_ADDR_W_P-$clog2(DATA_W_P/8)-1:0] mem_addr_o,
    output logic                                   mem_rd_en_o,
    output logic                                   mem_wr_en_o,
    output logic [DATA_W_P-1:0]                    mem_wdata_o,
    input  logic [DATA_W_P-1:0]                    mem_rdata_i
);
    localparam int        OFF     = $clog2(DATA_W_P / 8);
    localparam int        IDX_W   = (NUM_PORTS_P > 1) ? $clog2(NUM_PORTS_P) : 1;
    localparam t_mem_size FULL_SZ = (DATA_W_P == 64) ? SZ_DWORD : SZ_WORD;

    t_mau_state               r_state, w_next;
    logic [IDX_W-1:0]         r_port, w_idx;
    logic [NUM_PORTS_P-1:0]   w_gnt;
    logic                     w_any, w_take;
    logic                     r_we, r_err, r_uns;
    t_mem_size                r_size;
    logic [BYTE_ADDR_W_P-1:0] r_addr;
    logic [DATA_W_P-1:0]      r_data;

    logic [BYTE_ADDR_W_P-1:0] w_sel_addr;
    t_mem_size                w_sel_size;
    logic                     w_sel_we, w_sel_err;
    logic [2:0]               w_lane;

    mem_access_unit_rr_arbiter #(
        .NUM_PORTS_P (NUM_PORTS_P),
        .RR_MODE_P   (RR_MODE_P)
    ) u_arb (
        .i_clk  (clk_i),
        .i_rstn (rstn_i),
        .i_req  (req_valid_i),
        .i_take (w_take),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    assign w_take      = (r_state == ST_IDLE) && w_any;
    assign req_ready_o = (rstn_i && (r_state == ST_IDLE)) ? w_gnt : '0;

    assign w_sel_addr = req_addr_i[w_idx];
    assign w_sel_size = t_mem_size'(req_size_i[w_idx]);
    assign w_sel_we   = req_we_i[w_idx];
    assign w_sel_err  = misaligned(w_sel_addr[2:0], w_sel_size)
                        || ((w_sel_size == SZ_DWORD) && (DATA_W_P == 32));
    assign w_lane     = 3'(r_addr[OFF-1:0]);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        mem_rd_en_o = 1'b0;
        mem_wr_en_o = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    if (w_sel_err)                              w_next = ST_RESP;
                    else if (w_sel_we && w_sel_size == FULL_SZ) w_next = ST_WRITE;
                    else                                        w_next = ST_READ;
                end
            end
            ST_READ: begin
                mem_rd_en_o = 1'b1;
                w_next      = ST_WAIT;
            end
            ST_WAIT:  w_next = r_we ? ST_WRITE : ST_RESP;
            ST_WRITE: begin
                mem_wr_en_o = 1'b1;
                w_next      = ST_RESP;
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    // r_data holds store data from acceptance, then the loaded or merged word after WAIT.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_port <= '0;
            r_we   <= 1'b0;
            r_err  <= 1'b0;
            r_uns  <= 1'b0;
            r_size <= SZ_BYTE;
            r_addr <= '0;
            r_data <= '0;
        end else if (w_take) begin
            r_port <= w_idx;
            r_we   <= w_sel_we;
            r_err  <= w_sel_err;
            r_uns  <= req_unsigned_i[w_idx];
            r_size <= w_sel_size;
            r_addr <= w_sel_addr;
            r_data <= req_wdata_i[w_idx];
        end else if (r_state == ST_WAIT) begin
            r_data <= r_we ? DATA_W_P'(lane_merge(64'(mem_rdata_i), 64'(r_data), w_lane, r_size))
                           : DATA_W_P'(lane_extract(64'(mem_rdata_i), w_lane, r_size, r_uns));
        end
    end

    assign mem_addr_o  = (r_state inside {ST_READ, ST_WAIT, ST_WRITE}) ? r_addr[BYTE_ADDR_W_P-1:OFF] : '0;
    assign mem_wdata_o = (r_state == ST_WRITE) ? r_data : '0;

    always_comb begin
        rsp_valid_o = '0;
        rsp_err_o   = '0;
        rsp_rdata_o = '0;
        if (r_state == ST_RESP) begin
            rsp_valid_o[r_port] = 1'b1;
            rsp_err_o[r_port]   = r_err;
            rsp_rdata_o[r_port] = (r_we || r_err) ? '0 : r_data;
        end
    end

endmodule
